// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : booth_pkg
//  Description : Shared types and constants for the radix-4 Booth multiplier
//                controller: FSM state encoding, Booth digit codes and the
//                default operand width.
//  Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

    // Default operand width (must be even, and at least 4).
    localparam int DEFAULT_N = 8;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Booth digit codes presented on digit_sel.
    localparam logic [2:0] D_ZERO = 3'd0;  // 0
    localparam logic [2:0] D_PM   = 3'd1;  // +M
    localparam logic [2:0] D_P2M  = 3'd2;  // +2M
    localparam logic [2:0] D_NM   = 3'd3;  // -M
    localparam logic [2:0] D_N2M  = 3'd4;  // -2M

endpackage
`default_nettype wire

// File: rtl/booth_recoder.sv
`default_nettype none
// ============================================================================
//  Module      : booth_recoder
//  Description : Combinational radix-4 Booth recoder. Maps the overlapping
//                multiplier bit triple {Q[1], Q[0], q_1} to a digit code.
//  Ports       : bits      (in,  3) - {Q[1], Q[0], q_1}
//                digit_sel (out, 3) - digit code from booth_pkg
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_recoder
    import booth_pkg::*;
(
    input  logic [2:0] bits,
    output logic [2:0] digit_sel
);

    always_comb begin
        digit_sel = D_ZERO;
        case (bits)
            3'b001, 3'b010: digit_sel = D_PM;
            3'b011:         digit_sel = D_P2M;
            3'b100:         digit_sel = D_N2M;
            3'b101, 3'b110: digit_sel = D_NM;
            default:        digit_sel = D_ZERO;  // 000 and 111
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/radix4_booth_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : radix4_booth_ctrl
//  Description : Sequential radix-4 Booth signed multiplier. Retires two
//                multiplier bits per cycle; an N-bit multiply takes N/2 RUN
//                cycles plus one DONE cycle.
//  Ports       : clk       (in)       - clock, rising edge
//                rst       (in)       - asynchronous reset, active low
//                start     (in)       - request a multiply (taken in IDLE only)
//                mcand     (in,  N)   - signed multiplicand
//                mplier    (in,  N)   - signed multiplier
//                busy      (out)      - high in RUN and DONE
//                done      (out)      - one-cycle completion pulse
//                product   (out, 2N)  - signed result, held until next start
//                digit_sel (out, 3)   - current Booth digit (D_ZERO outside RUN)
//                iter      (out)      - current iteration (0 outside RUN)
//  Revision    : 1.0 - initial release
// ============================================================================
module radix4_booth_ctrl
    import booth_pkg::*;
#(
    parameter  int N      = DEFAULT_N,
    localparam int ITER_W = (N > 2) ? $clog2(N / 2) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N-1:0]      mcand,
    input  logic [N-1:0]      mplier,
    output logic              busy,
    output logic              done,
    output logic [2*N-1:0]    product,
    output logic [2:0]        digit_sel,
    output logic [ITER_W-1:0] iter
);

    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(N / 2 - 1);

    state_t            state;
    logic [N-1:0]      m_reg;
    logic [N+1:0]      a_reg;     // two guard bits so that -2M of -2^(N-1) fits
    logic [N-1:0]      q_reg;
    logic              q_1;
    logic [ITER_W-1:0] iter_reg;

    logic [2:0]        code;
    logic [N+1:0]      m_ext;
    logic [N+1:0]      m_dbl;
    logic [N+1:0]      addend;
    logic [N+1:0]      sum;

    booth_recoder u_recoder (
        .bits      ({q_reg[1:0], q_1}),
        .digit_sel (code)
    );

    assign m_ext = {{2{m_reg[N-1]}}, m_reg};
    assign m_dbl = {m_reg[N-1], m_reg, 1'b0};

    always_comb begin
        addend = '0;
        case (code)
            D_PM:    addend = m_ext;
            D_P2M:   addend = m_dbl;
            D_NM:    addend = -m_ext;
            D_N2M:   addend = -m_dbl;
            default: addend = '0;
        endcase
    end

    assign sum = a_reg + addend;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            m_reg    <= '0;
            a_reg    <= '0;
            q_reg    <= '0;
            q_1      <= 1'b0;
            iter_reg <= '0;
            product  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m_reg    <= mcand;
                        a_reg    <= '0;
                        q_reg    <= mplier;
                        q_1      <= 1'b0;
                        iter_reg <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    // Arithmetic shift of {sum, Q, q_1} right by two.
                    a_reg <= {{2{sum[N+1]}}, sum[N+1:2]};
                    q_reg <= {sum[1:0], q_reg[N-1:2]};
                    q_1   <= q_reg[1];
                    if (iter_reg == ITER_LAST) begin
                        // {A[N-1:0], Q} after the final shift.
                        product  <= {sum, q_reg[N-1:2]};
                        iter_reg <= '0;
                        state    <= DONE;
                    end else begin
                        iter_reg <= iter_reg + ITER_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign digit_sel = (state == RUN) ? code : D_ZERO;
    assign iter      = iter_reg;

endmodule
`default_nettype wire
